// File: rtl/alu_pkg.sv
// Shared types and default widths for the ALU operand stage.
// Imported by operand_ext and alu_operand_stage.
package alu_pkg;

  localparam int DATA_W_D     = 32;
  localparam int IMM_W_D      = 16;
  localparam int REG_ADDR_W_D = 5;

  typedef enum logic [1:0] {
    B_SEL_REG   = 2'd0,
    B_SEL_IMM   = 2'd1,
    B_SEL_UPPER = 2'd2,
    B_SEL_ZERO  = 2'd3
  } b_sel_e;

endpackage

// File: rtl/operand_ext.sv
// Immediate extension for operand B: zero/sign extend or upper placement.
// Register and zero selections yield zero here; the stage muxes them.
module operand_ext
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int IMM_W  = IMM_W_D
) (
  input  logic [IMM_W-1:0]  immediate,
  input  logic              ext_sign,
  input  logic [1:0]        b_sel,
  output logic [DATA_W-1:0] ext_val
);

  b_sel_e sel;
  logic   fill;

  assign sel  = b_sel_e'(b_sel);
  assign fill = ext_sign & immediate[IMM_W-1];

  // Build the extended value for the selected immediate form
  always_comb begin
    ext_val = '0;
    unique case (1'b1)
      (sel == B_SEL_IMM):
        ext_val = {{(DATA_W-IMM_W){fill}}, immediate};
      (sel == B_SEL_UPPER):
        ext_val = {immediate, {(DATA_W-IMM_W){1'b0}}};
      default:
        ext_val = '0;
    endcase
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Registered ALU operand select with a two-entry skid buffer.
// Define ALU_OPND_FWD_EN to add result forwarding at acceptance.
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int DATA_W     = DATA_W_D,
  parameter int IMM_W      = IMM_W_D,
  parameter int REG_ADDR_W = REG_ADDR_W_D
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic [DATA_W-1:0]     read_data1,
  input  logic [DATA_W-1:0]     read_data2,
  input  logic [IMM_W-1:0]      immediate,
  input  logic [1:0]            b_sel,
  input  logic                  ext_sign,
  input  logic                  flush,
`ifdef ALU_OPND_FWD_EN
  input  logic                  fwd_valid,
  input  logic [REG_ADDR_W-1:0] fwd_addr,
  input  logic [DATA_W-1:0]     fwd_data,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     op_a,
  output logic [DATA_W-1:0]     op_b
);

  logic [DATA_W-1:0] ext_val;
  logic [DATA_W-1:0] src1;
  logic [DATA_W-1:0] src2;
  logic [DATA_W-1:0] new_a;
  logic [DATA_W-1:0] new_b;
  logic              main_valid;
  logic              skid_valid;
  logic [DATA_W-1:0] main_a;
  logic [DATA_W-1:0] main_b;
  logic [DATA_W-1:0] skid_a;
  logic [DATA_W-1:0] skid_b;
  logic              acc;
  logic              drain;
  b_sel_e            sel;

  operand_ext #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W)
  ) u_ext (
    .immediate (immediate),
    .ext_sign  (ext_sign),
    .b_sel     (b_sel),
    .ext_val   (ext_val)
  );

`ifdef ALU_OPND_FWD_EN
  logic hit1;
  logic hit2;

  assign hit1 = fwd_valid && (fwd_addr == rs1_addr)
             && (rs1_addr != '0);
  assign hit2 = fwd_valid && (fwd_addr == rs2_addr)
             && (rs2_addr != '0);
  assign src1 = hit1 ? fwd_data : read_data1;
  assign src2 = hit2 ? fwd_data : read_data2;
`else
  logic unused_addr;

  assign unused_addr = ^{rs1_addr, rs2_addr};
  assign src1 = read_data1;
  assign src2 = read_data2;
`endif

  assign sel   = b_sel_e'(b_sel);
  assign new_a = src1;

  // Operand B source: register, extended immediate or zero
  always_comb begin
    new_b = ext_val;
    unique case (1'b1)
      (sel == B_SEL_REG): new_b = src2;
      default:            new_b = ext_val;
    endcase
  end

  assign in_ready  = !skid_valid;
  assign acc       = in_valid && in_ready;
  assign drain     = main_valid && out_ready;
  assign out_valid = main_valid;
  assign op_a      = main_a;
  assign op_b      = main_b;

  // Main/skid entries: refill main from skid first to keep FIFO order
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_a     <= '0;
      main_b     <= '0;
      skid_a     <= '0;
      skid_b     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (drain) begin
      if (skid_valid) begin
        main_a     <= skid_a;
        main_b     <= skid_b;
        skid_valid <= 1'b0;
      end else if (acc) begin
        main_a <= new_a;
        main_b <= new_b;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (acc) begin
      if (!main_valid) begin
        main_valid <= 1'b1;
        main_a     <= new_a;
        main_b     <= new_b;
      end else begin
        skid_valid <= 1'b1;
        skid_a     <= new_a;
        skid_b     <= new_b;
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage with a FIFO scoreboard.
// Forwarding steps run only when ALU_OPND_FWD_EN is defined.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [15:0] immediate;
  logic [1:0]  b_sel;
  logic        ext_sign;
  logic        flush;
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;

  logic [63:0] sb[$];
  logic [31:0] exp_a;
  logic [31:0] exp_b;
  logic        took;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          idx;
  int          guard;

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .immediate  (immediate),
    .b_sel      (b_sel),
    .ext_sign   (ext_sign),
    .flush      (flush),
`ifdef ALU_OPND_FWD_EN
    .fwd_valid  (fwd_valid),
    .fwd_addr   (fwd_addr),
    .fwd_data   (fwd_data),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .op_a       (op_a),
    .op_b       (op_b)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: record acceptance on the scoreboard, then step
  task automatic cycle();
    @(negedge clk);
    took = in_valid && in_ready && !flush && !rst;
    if (took) sb.push_back({exp_a, exp_b});
    if (flush || rst) sb.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [31:0] d1,
                        input logic [31:0] d2,
                        input logic [15:0] imm,
                        input logic [1:0]  bs,
                        input logic        sg,
                        input logic [31:0] ea,
                        input logic [31:0] eb);
    in_valid   = 1'b1;
    read_data1 = d1;
    read_data2 = d2;
    immediate  = imm;
    b_sel      = bs;
    ext_sign   = sg;
    exp_a      = ea;
    exp_b      = eb;
  endtask

  task automatic stream_op(input int k);
    set_op(k, k * 16, 16'h0, 2'd0, 1'b0, k, k * 16);
  endtask

  // Compare every handed-off operand pair against the queue head
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", {31'd0, out_valid}, 32'd0);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        check("op_a", op_a, e[63:32]);
        check("op_b", op_b, e[31:0]);
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
    out_ready = 1'b0; rs1_addr = '0; rs2_addr = '0;
    read_data1 = '0; read_data2 = '0; immediate = '0;
    b_sel = '0; ext_sign = 1'b0; fwd_valid = 1'b0;
    fwd_addr = '0; fwd_data = '0; exp_a = '0; exp_b = '0;
    took = 1'b0;

    cycle();
    cycle();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_op_a", op_a, 32'd0);
    check("rst_op_b", op_b, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;

    out_ready = 1'b1;
    set_op(32'hA1, 32'hB1, 16'h8001, 2'd1, 1'b0,
           32'hA1, 32'h0000_8001);
    cycle();
    in_valid = 1'b0;
    check("latency_1", {31'd0, out_valid}, 32'd1);
    cycle();

    set_op(32'hA2, 32'hB2, 16'h8001, 2'd1, 1'b1,
           32'hA2, 32'hFFFF_8001);
    cycle();
    set_op(32'hA3, 32'hB3, 16'h1234, 2'd2, 1'b1,
           32'hA3, 32'h1234_0000);
    cycle();
    set_op(32'hA4, 32'hB4, 16'h7FFF, 2'd1, 1'b1,
           32'hA4, 32'h0000_7FFF);
    cycle();
    set_op(32'hA5, 32'hB5, 16'hFFFF, 2'd3, 1'b1,
           32'hA5, 32'h0);
    cycle();
    set_op(32'hA6, 32'hCAFE_F00D, 16'hFFFF, 2'd0, 1'b1,
           32'hA6, 32'hCAFE_F00D);
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();

    out_ready = 1'b0;
    idx = 1;
    for (int c = 0; c < 3; c++) begin
      stream_op(idx);
      cycle();
      if (took) idx++;
    end
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_accepted", idx, 32'd3);
    check("bp_hold_a", op_a, 32'd1);
    check("bp_hold_b", op_b, 32'd16);
    out_ready = 1'b1;
    guard = 0;
    while (idx <= 5 && guard < 50) begin
      stream_op(idx);
      cycle();
      if (took) idx++;
      guard++;
    end
    in_valid = 1'b0;
    check("bp_all_sent", idx, 32'd6);
    for (int c = 0; c < 4; c++) cycle();
    check("bp_drained", sb.size(), 32'd0);

    out_ready = 1'b0;
    stream_op(10);
    cycle();
    stream_op(11);
    cycle();
    check("fl_pre_valid", {31'd0, out_valid}, 32'd1);
    stream_op(99);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_out_valid", {31'd0, out_valid}, 32'd0);
    check("fl_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) cycle();
    check("fl_no_ghost", {31'd0, out_valid}, 32'd0);

    out_ready = 1'b0;
    stream_op(20);
    cycle();
    stream_op(21);
    cycle();
    in_valid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("mr_out_valid", {31'd0, out_valid}, 32'd0);
    check("mr_op_a", op_a, 32'd0);
    check("mr_op_b", op_b, 32'd0);
    check("mr_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;

`ifdef ALU_OPND_FWD_EN
    fwd_valid = 1'b1;
    fwd_addr  = 5'd5;
    fwd_data  = 32'hDEAD;
    rs1_addr  = 5'd5;
    rs2_addr  = 5'd5;
    set_op(32'h0, 32'h77, 16'h0, 2'd0, 1'b0,
           32'hDEAD, 32'hDEAD);
    cycle();
    set_op(32'h0, 32'h77, 16'h0012, 2'd1, 1'b0,
           32'hDEAD, 32'h0000_0012);
    cycle();
    rs1_addr = 5'd0;
    rs2_addr = 5'd0;
    fwd_addr = 5'd0;
    set_op(32'h0, 32'h77, 16'h0, 2'd0, 1'b0,
           32'h0, 32'h77);
    cycle();
    fwd_valid = 1'b0;
    in_valid  = 1'b0;
`else
    rs1_addr = 5'd5;
    set_op(32'h0, 32'h77, 16'h0, 2'd0, 1'b0,
           32'h0, 32'h77);
    cycle();
    in_valid = 1'b0;
`endif

    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      cycle();
      guard++;
    end
    check("final_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
